// File: rtl/seq_mul_div.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply and
// restoring divide on operand magnitudes, UNROLL bits retired per cycle.
module seq_mul_div #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);
  localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  state_e            state, state_n;
  logic [CNT_W-1:0]  step_cnt;

  // Latched request and iteration datapath
  op_e               op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q;
  logic              div0_q;
  logic              ovf_q;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   hi;
  logic [XLEN-1:0]   lo;

  logic              accept;
  logic              signed_a, signed_b;
  logic              sign_a, sign_b;
  logic              neg_in;
  logic              div0_in, ovf_in, special_in;
  logic [XLEN-1:0]   a_mag, b_mag;

  logic [XLEN-1:0]   hi_n, lo_n;
  logic [XLEN:0]     acc_t;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot, remd;
  logic [XLEN-1:0]   fix_result;

  assign in_ready  = (state == IDLE) && !flush;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  // Operand decode at accept time: magnitudes plus the final negate flag.
  always_comb begin
    op_e op_in;
    op_in    = op_e'(op);
    signed_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    signed_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    sign_a   = signed_a && rs1[XLEN-1];
    sign_b   = signed_b && rs2[XLEN-1];
    a_mag    = sign_a ? -rs1 : rs1;
    b_mag    = sign_b ? -rs2 : rs2;
    // Remainder follows the dividend; everything else follows the product sign.
    neg_in   = (op_in == OP_REM) ? sign_a : (sign_a ^ sign_b);
    div0_in  = op[2] && (rs2 == '0);
    ovf_in   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (rs1 == MOST_NEG) && (rs2 == '1);
    special_in = div0_in || ovf_in;
  end

  // One BUSY cycle worth of iteration, UNROLL radix-2 steps chained.
  // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    hi_n  = hi;
    lo_n  = lo;
    acc_t = '0;
    for (int u = 0; u < UNROLL; u++) begin
      if (op_q[2]) begin
        acc_t = {hi_n, lo_n[XLEN-1]};
        lo_n  = {lo_n[XLEN-2:0], 1'b0};
        if (acc_t >= {1'b0, mcand}) begin
          acc_t   = acc_t - {1'b0, mcand};
          lo_n[0] = 1'b1;
        end
        hi_n = acc_t[XLEN-1:0];
      end else begin
        acc_t = {1'b0, hi_n} + {1'b0, mcand & {XLEN{lo_n[0]}}};
        lo_n  = {acc_t[0], lo_n[XLEN-1:1]};
        hi_n  = acc_t[XLEN:1];
      end
    end
  end

  // Sign correction and half selection, registered on the FIX->DONE edge.
  always_comb begin
    prod     = {hi, lo};
    prod_fix = neg_q ? -prod : prod;
    quot     = neg_q ? -lo : lo;
    remd     = neg_q ? -hi : hi;
    unique case (op_q)
      OP_MUL:                       fix_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:  fix_result = div0_q ? '1 : (ovf_q ? lo : quot);
      OP_REM, OP_REMU:  fix_result = div0_q ? lo : (ovf_q ? '0 : remd);
      default:          fix_result = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (accept) state_n = special_in ? FIX : BUSY;
      BUSY: if (step_cnt == LAST_STEP) state_n = FIX;
      FIX:  state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      step_cnt <= '0;
      result   <= '0;
      out_tag  <= '0;
    end else begin
      state <= state_n;
      if ((state == BUSY) && !flush && (step_cnt != LAST_STEP))
        step_cnt <= step_cnt + CNT_W'(1);
      else
        step_cnt <= '0;
      if ((state == FIX) && !flush) begin
        result  <= fix_result;
        out_tag <= tag_q;
      end
    end
  end

  // NOTE: operand/iteration registers are always loaded before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_e'(op);
      tag_q  <= in_tag;
      neg_q  <= neg_in;
      div0_q <= div0_in;
      ovf_q  <= ovf_in;
      mcand  <= b_mag;
      hi     <= '0;
      // Special cases skip the iteration and need the raw dividend in FIX.
      lo     <= special_in ? rs1 : a_mag;
    end else if (state == BUSY) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

endmodule

// File: tb/tb_seq_mul_div.sv
// Directed self-checking bench for seq_mul_div (UNROLL=1 and UNROLL=4 instances).
module tb_seq_mul_div;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0, in_valid4 = 1'b0;
  logic             flush = 1'b0, flush4 = 1'b0;
  logic             out_ready = 1'b0, out_ready4 = 1'b0;
  logic [2:0]       op = 3'b000;
  logic [XLEN-1:0]  rs1 = '0, rs2 = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready, out_valid, busy;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             in_ready4, out_valid4, busy4;
  logic [XLEN-1:0]  result4;
  logic [TAG_W-1:0] out_tag4;

  int n_checks = 0;
  int n_errors = 0;

  seq_mul_div #(.XLEN(XLEN), .UNROLL(1), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs1(rs1), .rs2(rs2), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_tag(out_tag), .busy(busy)
  );

  seq_mul_div #(.XLEN(XLEN), .UNROLL(4), .TAG_W(TAG_W)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .op(op), .rs1(rs1), .rs2(rs2), .in_tag(in_tag), .flush(flush4),
    .out_valid(out_valid4), .out_ready(out_ready4), .result(result4),
    .out_tag(out_tag4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] t);
    check("in_ready before issue", sel ? in_ready4 : in_ready, 1'b1);
    op = o; rs1 = a; rs2 = b; in_tag = t;
    if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
    tick();  // accept edge E0
    in_valid = 1'b0; in_valid4 = 1'b0;
  endtask

  // Counts edges after E0 until out_valid is seen high; bounded at 100.
  task automatic wait_done(input bit sel, output int edges, output int busy_low);
    edges = 0; busy_low = 0;
    while (!(sel ? out_valid4 : out_valid) && edges < 100) begin
      tick();
      edges++;
      if (!(sel ? busy4 : busy)) busy_low++;
    end
  endtask

  task automatic pop(input bit sel);
    if (sel) out_ready4 = 1'b1; else out_ready = 1'b1;
    tick();
    out_ready = 1'b0; out_ready4 = 1'b0;
    check("idle after pop", {sel ? busy4 : busy, sel ? out_valid4 : out_valid}, 2'b00);
  endtask

  // out_valid goes high after edge k; the consumer samples it at edge k+1,
  // which is the edge the latency figures (E2, E(N+2)) refer to.
  task automatic run_op(input string name, input bit sel, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                        input int exp_edge, input logic [31:0] exp_res);
    int edges, busy_low;
    issue(sel, o, a, b, t);
    wait_done(sel, edges, busy_low);
    check({name, " latency"}, edges + 1, exp_edge);
    check({name, " busy"}, busy_low, 0);
    check({name, " result"}, sel ? result4 : result, exp_res);
    check({name, " tag"}, sel ? out_tag4 : out_tag, t);
    pop(sel);
  endtask

  initial begin
    int edges, busy_low, spurious;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset result", result, 32'h0);
    check("reset out_tag", out_tag, 5'd0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check("in_ready after release", in_ready, 1'b1);

    // Multiply family
    run_op("MUL 7*-3", 0, MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 34, 32'hFFFF_FFEB);
    run_op("MULHU", 0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 34, 32'hFFFF_FFFE);
    run_op("MULH", 0, MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 34, 32'h0000_0000);
    run_op("MULHSU -1*2", 0, MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd3, 34, 32'hFFFF_FFFF);

    // Divide-by-zero and signed overflow take the two-edge path
    run_op("DIVU by 0", 0, DIVU, 32'd77, 32'd0, 5'd4, 2, 32'hFFFF_FFFF);
    run_op("REM by 0", 0, REM, 32'h1234_5678, 32'd0, 5'd6, 2, 32'h1234_5678);
    run_op("DIV ovf", 0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 2, 32'h8000_0000);
    run_op("REM ovf", 0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 2, 32'h0000_0000);

    // Signed divide with back-pressure: result held while out_ready is low
    issue(0, DIV, 32'hFFFF_FFF9, 32'd2, 5'd9);
    wait_done(0, edges, busy_low);
    check("DIV -7/2 latency", edges + 1, 34);
    for (int i = 0; i < 5; i++) begin
      check("DIV hold out_valid", out_valid, 1'b1);
      check("DIV hold result", result, 32'hFFFF_FFFD);
      tick();
    end
    check("DIV hold tag", out_tag, 5'd9);
    pop(0);

    // Result keeps the last DONE value while the next op is in flight
    issue(0, REM, 32'hFFFF_FFF9, 32'd2, 5'd10);
    repeat (5) tick();
    check("result held during BUSY", result, 32'hFFFF_FFFD);
    wait_done(0, edges, busy_low);
    check("REM -7%2 result", result, 32'hFFFF_FFFF);
    pop(0);

    run_op("DIV 7/-2", 0, DIV, 32'd7, 32'hFFFF_FFFE, 5'd11, 34, 32'hFFFF_FFFD);
    run_op("REM 7%-2", 0, REM, 32'd7, 32'hFFFF_FFFE, 5'd12, 34, 32'h0000_0001);

    // out_ready while idle does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_ready in IDLE busy", busy, 1'b0);
    check("out_ready in IDLE result", result, 32'h0000_0001);

    // Flush mid-BUSY with a competing request: flush wins
    issue(0, MUL, 32'd7, 32'd9, 5'd13);
    repeat (10) tick();
    flush = 1'b1; in_valid = 1'b1; op = MULHU; rs1 = 32'd3; rs2 = 32'd4; in_tag = 5'd14;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush -> idle", busy, 1'b0);
    check("flush out_valid", out_valid, 1'b0);
    check("flush result held", result, 32'h0000_0001);
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid || busy) spurious++;
    end
    check("no activity after flush", spurious, 0);
    run_op("DIVU after flush", 0, DIVU, 32'd100, 32'd7, 5'd15, 34, 32'd14);
    run_op("REMU 100%7", 0, REMU, 32'd100, 32'd7, 5'd16, 34, 32'd2);

    // UNROLL=4 instance: same product in N+2 = 10 edges
    run_op("MUL unroll4", 1, MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 10, 32'hFFFF_FFEB);
    run_op("DIV unroll4", 1, DIV, 32'hFFFF_FFF9, 32'd2, 5'd17, 10, 32'hFFFF_FFFD);

    // Asynchronous reset mid-BUSY clears outputs without waiting for an edge
    issue(0, MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("async reset result", result, 32'h0);
    check("async reset out_tag", out_tag, 5'd0);
    check("async reset busy", busy, 1'b0);
    check("async reset out_valid", out_valid, 1'b0);
    #2 reset = 1'b0;
    spurious = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) spurious++;
    end
    check("no out_valid after reset", spurious, 0);
    check("in_ready after reset", in_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_mul_div.md
SEQ_MUL_DIV -- requirements
Module: seq_mul_div

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 or 64.
REQ-002 SHALL have parameter UNROLL, default 1, radix bits retired per BUSY cycle; legal values 1, 2 or 4, and it must divide XLEN.
REQ-003 SHALL have parameter TAG_W, default 5, width of the pass-through destination tag.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request this cycle.
REQ-008 op  input  3  RV M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-009 rs1 / rs2  input  XLEN each  operand1 / operand2 (dividend / divisor for the divide ops).
REQ-010 in_tag  input  TAG_W  destination register index, returned unchanged.
REQ-011 flush  input  1  synchronous kill of the in-flight operation.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  XLEN  final result.
REQ-015 out_tag  output  TAG_W  tag of the result.
REQ-016 busy  output  1  high whenever state != IDLE; drives the pipeline stall.

Function
REQ-017 FSM states: IDLE, BUSY, FIX, DONE.
REQ-018 in_ready SHALL be 1 only in IDLE with flush=0.
REQ-019 Accept: in_valid & in_ready at an edge latches op, operands and tag, and moves IDLE->BUSY.
REQ-020 Define N = XLEN/UNROLL. BUSY SHALL last exactly N cycles, counted by a step counter; each cycle retires UNROLL bits.
  - Multiply: shift-add on magnitudes.
  - Divide: restoring divide on magnitudes.
REQ-021 After the Nth step the FSM SHALL go BUSY->FIX for one cycle to apply sign correction and select the high or low half, then FIX->DONE.
REQ-022 out_valid SHALL be 1 exactly when in DONE. With accept edge E0, out_valid first rises after edge E(N+2); XLEN=32, UNROLL=1 gives 34 edges.
REQ-023 In DONE, result and out_tag SHALL be held stable until out_valid & out_ready, which moves DONE->IDLE at that edge.
REQ-024 Multiply results:
  - MUL returns the low XLEN bits of the product.
  - MULH: signed x signed, high half.
  - MULHSU: signed rs1 x unsigned rs2, high half.
  - MULHU: unsigned x unsigned, high half.
  - The full product is 2*XLEN bits internally.
REQ-025 Signed divide rules: DIV/REM truncate toward zero; the remainder takes the sign of the dividend.
REQ-026 Divide by zero (rs2==0) SHALL skip BUSY and go IDLE->FIX->DONE, with out_valid after edge E2.
  - DIV/DIVU return all ones.
  - REM/REMU return rs1.
REQ-027 Signed overflow (DIV/REM with rs1 = most-negative and rs2 = -1) SHALL take the same 2-edge path.
  - DIV returns rs1.
  - REM returns 0.
REQ-028 flush=1 at an edge SHALL force IDLE from any state; out_valid is 0 after that edge and the result is discarded.
REQ-029 flush and in_valid together: flush wins, nothing is accepted.
REQ-030 out_ready asserted outside DONE SHALL have no effect.
REQ-031 In IDLE/BUSY/FIX, result and out_tag SHALL hold their last DONE value and never show partial values.

Reset
REQ-032 reset=1 SHALL immediately set:
  - state IDLE, step counter 0
  - out_valid 0, busy 0, in_ready 1 (after release)
  - result 0, out_tag 0
REQ-033 reset asserted mid-operation SHALL abandon the operation; no out_valid pulse follows release.

Verification
REQ-034 MUL rs1=7, rs2=0xFFFFFFFD (-3), tag=5 (XLEN=32, UNROLL=1) -> out_valid after edge E34, result=0xFFFFFFEB, out_tag=5, busy high E1..E34.
REQ-035 MULHU and MULH, rs1=rs2=0xFFFFFFFF -> MULHU result=0xFFFFFFFE; MULH result=0x00000000.
REQ-036 Edge cases, each with out_valid after E2:
  - DIVU rs2=0 -> 0xFFFFFFFF.
  - REM rs1=0x12345678, rs2=0 -> 0x12345678.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
REQ-037 DIV rs1=0xFFFFFFF9 (-7), rs2=2 with out_ready=0 for 5 cycles after DONE -> result=0xFFFFFFFD held 5 cycles, IDLE one edge after out_ready=1. REM of the same operands -> 0xFFFFFFFF.
REQ-038 flush pulsed at BUSY step 10 with in_valid=1 that cycle -> IDLE next edge, no accept, no out_valid. A new request afterwards completes normally.
REQ-039 Repeat REQ-034 with UNROLL=4 -> out_valid after E10, same result. Async reset mid-BUSY -> outputs zero immediately.
